// File: rtl/alu_exec_unit_if.sv
// Handshake and operand bundle between the operand-select stage, the execute ALU and its consumer.
// Latency: none, wiring only.
// Backpressure: carries IN_VALID/IN_READY upstream and OUT_VALID/OUT_READY downstream, plus FLUSH.
interface alu_exec_unit_if;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] DATA0;
  logic [31:0] DATA1;
  logic        ALU_EN;
  logic [6:0]  OPCODE;
  logic [2:0]  FUNCT3;
  logic        INSTR30;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RESULT;
  logic        BUSY;

  // Driver side: issues operations and consumes results.
  modport master (
    output FLUSH, IN_VALID, DATA0, DATA1, ALU_EN, OPCODE, FUNCT3, INSTR30, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, BUSY
  );

  // ALU side.
  modport slave (
    input  FLUSH, IN_VALID, DATA0, DATA1, ALU_EN, OPCODE, FUNCT3, INSTR30, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, BUSY
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU with an iterative shifter advancing SHIFT_STEP bits per cycle.
// Latency: 1 cycle for non-shift ops, 1 + ceil(shamt/SHIFT_STEP) for shifts with shamt > 0.
// Backpressure: result held in DONE until OUT_READY; IN_READY follows OUT_READY in DONE, low in SHIFT/FLUSH/reset.
module alu_exec_unit #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic          clk,
  input  logic          reset,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [4:0] STEP_AMT = 5'(SHIFT_STEP);

  state_e      state_q, state_d;
  op_e         sh_op_q, sh_op_d;
  logic [31:0] result_q, result_d;
  logic [31:0] shreg_q, shreg_d;
  logic [4:0]  rem_q, rem_d;

  op_e         dec_op;
  logic        is_shift;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic [4:0]  step_amt;
  logic [31:0] shifted;
  logic        accept;

  assign shamt    = bus.DATA1[4:0];
  assign is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);

  // A new op may enter from IDLE, or from DONE when the held result leaves this same cycle.
  assign bus.IN_READY  = !reset && !bus.FLUSH &&
                         ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.OUT_READY));
  assign accept        = bus.IN_VALID && bus.IN_READY;
  assign bus.OUT_VALID = (state_q == S_DONE);
  assign bus.BUSY      = (state_q == S_SHIFT);
  assign bus.RESULT    = result_q;

  // Decode the operation; loads, stores, LUI and AUIPC (and anything unrecognised) use the adder.
  always_comb begin
    dec_op = OP_ADD;
    if ((bus.OPCODE == OPC_R) || (bus.OPCODE == OPC_I)) begin
      case (bus.FUNCT3)
        3'b000:  dec_op = ((bus.OPCODE == OPC_R) && bus.INSTR30) ? OP_SUB : OP_ADD;
        3'b001:  dec_op = OP_SLL;
        3'b010:  dec_op = OP_SLT;
        3'b011:  dec_op = OP_SLTU;
        3'b100:  dec_op = OP_XOR;
        3'b101:  dec_op = bus.INSTR30 ? OP_SRA : OP_SRL;
        3'b110:  dec_op = OP_OR;
        default: dec_op = OP_AND;
      endcase
    end
  end

  // Single-cycle datapath; a shift reaching here has shamt 0, so it passes DATA0 through.
  always_comb begin
    alu_res = bus.DATA0 + bus.DATA1;
    case (dec_op)
      OP_SUB:  alu_res = bus.DATA0 - bus.DATA1;
      OP_SLT:  alu_res = {31'd0, $signed(bus.DATA0) < $signed(bus.DATA1)};
      OP_SLTU: alu_res = {31'd0, bus.DATA0 < bus.DATA1};
      OP_XOR:  alu_res = bus.DATA0 ^ bus.DATA1;
      OP_OR:   alu_res = bus.DATA0 | bus.DATA1;
      OP_AND:  alu_res = bus.DATA0 & bus.DATA1;
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.DATA0;
      default: alu_res = bus.DATA0 + bus.DATA1;
    endcase
  end

  // One shifter step: min(SHIFT_STEP, remaining) bits in the captured direction.
  always_comb begin
    step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    case (sh_op_q)
      OP_SLL:  shifted = shreg_q << step_amt;
      OP_SRA:  shifted = $signed(shreg_q) >>> step_amt;
      default: shifted = shreg_q >> step_amt;
    endcase
  end

  // Next-state logic; FLUSH overrides every transition and returns to IDLE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    sh_op_d  = sh_op_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && bus.OUT_READY) state_d = S_IDLE;
        if (accept) begin
          if (!bus.ALU_EN) begin
            state_d = S_IDLE;
          end else if (is_shift && (shamt != 5'd0)) begin
            state_d = S_SHIFT;
            shreg_d = bus.DATA0;
            rem_d   = shamt;
            sh_op_d = dec_op;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = shifted;
        rem_d   = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d  = S_DONE;
          result_d = shifted;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.FLUSH) begin
      state_d = S_IDLE;
      rem_d   = 5'd0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= 32'h0;
      shreg_q  <= 32'h0;
      rem_q    <= 5'd0;
      sh_op_q  <= OP_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      shreg_q  <= shreg_d;
      rem_q    <= rem_d;
      sh_op_q  <= sh_op_d;
    end
  end

endmodule
